// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential 8-bit binary to 3-digit BCD converter.
// It uses the shift-add-3 (double dabble) method and handles one operand
// bit per clock, most significant bit first. A conversion takes 8 CONV
// cycles and then a single DONE cycle. The result digits are registered
// when the FSM enters DONE. They then hold their value until the next
// conversion completes or a reset occurs.
module bin_to_bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Applies the double-dabble correction to one BCD digit. A digit of 5 or
  // more is adjusted so that the following shift carries into the next digit.
  function automatic logic [3:0] add3(input logic [3:0] digit);
    logic [3:0] res;
    if (digit >= 4'd5) begin
      res = digit + 4'd3;
    end else begin
      res = digit;
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [19:0] work_q, work_d;     // {bcd[11:0], remaining binary bits}
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;

  logic [11:0] adj_s;              // BCD part after add-3 correction
  logic [19:0] shift_s;            // working register after one full step

  // Computes one double-dabble step: correct all three digits in parallel, then shift left by one
  always_comb begin
    adj_s   = {add3(work_q[19:16]), add3(work_q[15:12]), add3(work_q[11:8])};
    shift_s = {adj_s[10:0], work_q[7:0], 1'b0};
  end

  // Next-state and next-output logic; every register holds its value unless a branch updates it
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = {12'h000, bin};
          cnt_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        work_d = shift_s;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Final bit is being shifted in: capture the completed digits now
          state_d = S_DONE;
          done_d  = 1'b1;
          hund_d  = shift_s[19:16];
          tens_d  = shift_s[15:12];
          ones_d  = shift_s[11:8];
        end else begin
          busy_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        work_d  = 20'h00000;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State, working register and registered outputs; reset clears everything asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= 20'h00000;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hundreds = hund_q;
  assign tens     = tens_q;
  assign ones     = ones_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed self-checking bench for bin_to_bcd_seq.
// It checks the reset state, the latency, a set of known vectors,
// start-while-busy, start held high, reset in mid-conversion and a full sweep.
module tb_bin_to_bcd_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge. Runs one conversion with a one-cycle start pulse and
  // returns at the negedge of cycle N+10 (IDLE), where N is the accepting edge.
  task automatic convert(input logic [7:0] b, input logic [11:0] exp, input string tag);
    int busy_cnt;
    int overlap;
    busy_cnt = 0;
    overlap  = 0;
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      bin   = ~b;                       // operand changes during CONV must not matter
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b0) overlap++;
    end
    chk({tag, "_busy8"}, 16'(busy_cnt), 16'd8);
    chk({tag, "_nodone_conv"}, 16'(overlap), 16'd0);
    @(negedge clk);
    chk({tag, "_done"}, {14'd0, busy, done}, 16'b01);
    chk({tag, "_digits"}, {4'd0, hundreds, tens, ones}, {4'd0, exp});
    @(negedge clk);
    chk({tag, "_done_width"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    int dcount;
    int hold_bad;
    logic [11:0] exp;

    rst   = 1'b1;
    start = 1'b0;
    bin   = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {4'd0, hundreds, tens, ones}, 16'h0000);
    chk("reset_flags", {14'd0, busy, done}, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Known vectors
    convert(8'd0,   12'h000, "v0");
    convert(8'd255, 12'h255, "v255");
    convert(8'd100, 12'h100, "v100");
    convert(8'd99,  12'h099, "v99");
    convert(8'd9,   12'h009, "v9");

    // A second start pulse at start+3 is ignored; the result is 123 and then holds
    start = 1'b1;
    bin   = 8'd123;
    @(posedge clk);
    dcount = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      start = (i == 3) ? 1'b1 : 1'b0;
      bin   = (i == 3) ? 8'd45 : 8'd0;
      if (i == 9) begin
        chk("ign_done", {15'd0, done}, 16'd1);
        chk("ign_digits", {4'd0, hundreds, tens, ones}, 16'h0123);
      end
    end
    hold_bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dcount++;
      if ({hundreds, tens, ones} !== 12'h123) hold_bad++;
    end
    chk("ign_no_second", 16'(dcount), 16'd0);
    chk("ign_hold", 16'(hold_bad), 16'd0);

    // Start held high: a conversion every 10 cycles, and bin is re-sampled at each acceptance
    start = 1'b1;
    bin   = 8'd200;
    @(posedge clk);
    @(negedge clk);
    bin = 8'd17;
    repeat (8) @(negedge clk);
    chk("held_done1", {15'd0, done}, 16'd1);
    chk("held_dig1", {4'd0, hundreds, tens, ones}, 16'h0200);
    dcount = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("held_gap", 16'(dcount), 16'd0);
    @(negedge clk);
    start = 1'b0;
    chk("held_done2", {15'd0, done}, 16'd1);
    chk("held_dig2", {4'd0, hundreds, tens, ones}, 16'h0017);
    @(negedge clk);
    chk("held_idle", {14'd0, busy, done}, 16'd0);

    // Reset asserted mid-conversion aborts the conversion immediately
    start = 1'b1;
    bin   = 8'd250;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_flags", {14'd0, busy, done}, 16'd0);
    chk("rst_async_outs", {4'd0, hundreds, tens, ones}, 16'h0000);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dcount++;
    end
    chk("rst_no_done", 16'(dcount), 16'd0);
    rst = 1'b0;
    convert(8'd250, 12'h250, "restart250");

    // Exhaustive sweep against a decimal reference
    for (int v = 0; v < 256; v++) begin
      exp = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      convert(8'(v), exp, "sweep");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
